// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (core vs host loader).
// Optional host burst priority is enabled by defining DM_ARB_HOST_BURST_EN.
module dm_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              h_req,
  input  logic              c_we,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              c_gnt,
  output logic              h_gnt,
  output logic              c_done,
  output logic              h_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_H = 1'b1;
  // Illegal parameter sets leave the arbiter inert rather than misbehaving.
  localparam bit CFG_OK = (MEM_LAT >= 1) && (MEM_LAT <= 15) && (BURST_MAX >= 1);

  logic [1:0]        state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              c_gnt_q, c_gnt_d, h_gnt_q, h_gnt_d;
  logic              c_done_q, c_done_d, h_done_q, h_done_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, h_rdata_q, h_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic req_any;
  logic grant;
  logic host_wins;
  logic burst_ok;

  assign req_any   = CFG_OK && (c_req || h_req);
  assign grant     = (state_q == S_IDLE) && req_any;
  assign host_wins = h_req && (!c_req || (last_q == PORT_C) || burst_ok);

`ifdef DM_ARB_HOST_BURST_EN
  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);
  logic [BURST_W-1:0] burst_q, burst_d;

  assign burst_ok = (last_q == PORT_H) && (burst_q < BURST_W'(BURST_MAX));

  // Count consecutive host grants; any core grant restarts the run.
  always_comb begin
    burst_d = burst_q;
    if (grant) begin
      if (!host_wins) begin
        burst_d = '0;
      end else if (burst_q < BURST_W'(BURST_MAX)) begin
        burst_d = burst_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign burst_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_gnt_d   = 1'b0;
    h_gnt_d   = 1'b0;
    c_done_d  = 1'b0;
    h_done_d  = 1'b0;
    c_rdata_d = c_rdata_q;
    h_rdata_d = h_rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          win_d    = host_wins;
          last_d   = host_wins;
          we_d     = host_wins ? h_we    : c_we;
          addr_d   = host_wins ? h_addr  : c_addr;
          wdata_d  = host_wins ? h_wdata : c_wdata;
          mem_en_d = 1'b1;
          mem_we_d = host_wins ? h_we : c_we;
          c_gnt_d  = !host_wins;
          h_gnt_d  = host_wins;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? S_CAPT : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (win_q == PORT_H) begin
          h_done_d = 1'b1;
          if (!we_q) h_rdata_d = mem_rdata;
        end else begin
          c_done_d = 1'b1;
          if (!we_q) c_rdata_d = mem_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      win_q     <= PORT_C;
      last_q    <= PORT_H;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_gnt_q   <= 1'b0;
      h_gnt_q   <= 1'b0;
      c_done_q  <= 1'b0;
      h_done_q  <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_gnt_q   <= c_gnt_d;
      h_gnt_q   <= h_gnt_d;
      c_done_q  <= c_done_d;
      h_done_q  <= h_done_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
    end
  end

  assign c_gnt     = c_gnt_q;
  assign h_gnt     = h_gnt_q;
  assign c_done    = c_done_q;
  assign h_done    = h_done_q;
  assign c_rdata   = c_rdata_q;
  assign h_rdata   = h_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the single-port data memory of the matrix-multiplication processor. It shares the memory between the processor core, which issues load/store through AR/DR, and the host loader, which preloads the X/Y matrices and reads back results. It serializes accesses, drives the memory enable/write strobes, waits a fixed memory latency, and returns read data and completion to the winning requester. It replaces the direct `dm_en` drive from the core.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `MEM_LAT`, 1: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal values are 1..15.
- `BURST_MAX`, 4: maximum consecutive host grants. Used only with `DM_ARB_HOST_BURST_EN`.

Ports:
- `clk` in 1: single clock. All logic is clocked on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `c_req`, `h_req` in 1 each: access request from core / host.
- `c_we`, `h_we` in 1 each: 1 = write, 0 = read.
- `c_addr`, `h_addr` in ADDR_W each: access address.
- `c_wdata`, `h_wdata` in DATA_W each: write data.
- `c_gnt`, `h_gnt` out 1 each: one-cycle pulse when the command is issued to memory.
- `c_done`, `h_done` out 1 each: one-cycle pulse when the access is complete.
- `c_rdata`, `h_rdata` out DATA_W each: read data. Valid with `done` after a read; held until the next read completes for that port.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPT.
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick the winner, latch its `we`/`addr`/`wdata` into the command registers, record the winner id, and go to ISSUE.
- ISSUE (1 cycle):
  - `mem_en`=1, `mem_we`=latched `we`; `mem_addr`/`mem_wdata` come from the command registers.
  - The winner's `gnt`=1.
  - Load `cnt`=MEM_LAT-1.
  - Next state is CAPT if MEM_LAT==1, otherwise WAIT.
- WAIT: decrement `cnt`. When `cnt` reaches 1, go to CAPT.
- CAPT (1 cycle):
  - On a read, register `mem_rdata` into the winner's `rdata`.
  - Register the winner's `done`=1.
  - Return to IDLE.
- Arbitration (IDLE only):
  - A single requester wins.
  - If both request, round-robin: the port not served last wins.
  - The `last` flag resets to host, so the core wins the first tie.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt`.
  - Drop or change them in the cycle after `gnt`.
  - A `req` still high at IDLE is treated as a new access.
- Outside ISSUE, `mem_en`=0 and `mem_we`=0. `mem_addr`/`mem_wdata` hold the last command.
- Same-address hazards are resolved by grant order only. There is no forwarding.

## Timing
- Reset value of every output is 0, with FSM=IDLE, `last`=host, `cnt`=0 and the burst counter=0.
- Reset asserted mid-access: the access is abandoned immediately. No `done` is issued, and `mem_en` drops asynchronously.
- Request first sampled high in IDLE at edge t:
  - ISSUE/`gnt`/`mem_en` during cycle t+1.
  - `mem_rdata` is sampled at the end of cycle t+1+MEM_LAT (the CAPT cycle).
  - `done`/`rdata` are visible in cycle t+2+MEM_LAT, and the FSM is in IDLE in that same cycle.
- Back-to-back throughput is one access per MEM_LAT+2 cycles.
- `c_done` and `h_done` are never high in the same cycle. Neither are `c_gnt` and `h_gnt`.

## Configuration
- `DM_ARB_HOST_BURST_EN` defined:
  - If the host was served last, `h_req` is high, and the burst counter < BURST_MAX, the host wins even when `c_req` is high.
  - The burst counter increments per host grant and clears on any core grant.
  - The core is therefore delayed by at most BURST_MAX host accesses.
- Not defined: strict round-robin. `BURST_MAX` is unused and the burst counter is not built.

## Test plan
- Reset, then a core read of addr 0x0010 with MEM_LAT=1 and `mem_rdata`=0xA5 -> `c_gnt` 1 cycle after the request, `c_done` with `c_rdata`=0xA5 3 cycles after the request, `h_*` outputs stay 0.
- Host write of 0x3C to 0x0200 with MEM_LAT=3 -> `mem_en`=`mem_we`=1 for exactly one cycle with addr 0x0200 and data 0x3C, then `h_done` 4 cycles later.
- `c_req` and `h_req` held high for 4 reads -> grant order core, host, core, host, with a period of MEM_LAT+2 cycles.
- With `DM_ARB_HOST_BURST_EN` and BURST_MAX=4, both requesting continuously, the first grant forced to host -> grant order H,H,H,H,C,H,H,H,H,C.
- `rst` pulled low in the WAIT state -> all outputs 0 immediately. After release, a new core read completes normally, no stale `done` appears, and the core wins the first tie.
- Core read of 0x0040 followed by a host write to 0x0040, with `h_gnt` preceding `c_gnt` -> the core reads the new value, confirming grant-order serialization.
